dec_scan_ctrl: RTL
==================

Name: dec_scan_ctrl

Overview:
- Upstream sequencer for the 2-to-4 decoder (dec2to4). Produces the decoder's 2-bit select and enable.
- Walks the four decoder lines in ascending order, holding each for a programmable dwell time and skipping masked lines.
- Runs one pass (one-shot) or wraps continuously until stopped.

Parameters:
DWELL_W, 8, width of dwell input and internal dwell down-counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin scanning; sampled only in IDLE
stop  input  1  abort scan; sampled in SCAN/BLANK
one_shot  input  1  1 = single pass, 0 = continuous; latched on accepted start
dwell  input  DWELL_W  cycles each line is enabled; 0 treated as 1; latched on accepted start
mask  input  4  bit i = 1 enables line i; latched on accepted start
sel  output  2  line select to decoder input
en  output  1  decoder enable
busy  output  1  high while in SCAN or BLANK
done  output  1  one-cycle pulse at end of a one-shot pass
line_strobe  output  1  pulse on first enabled cycle of each line

Behaviour:
- Single clock, clk. Synchronous active-high reset rst. All outputs are registered.
- Reset (also mid-operation): at the next edge, state=IDLE and sel=0, en=0, busy=0, done=0, line_strobe=0. Latched mask, dwell and mode are cleared.
- States: IDLE, SCAN, BLANK (only with macro), DONE.
- IDLE:
  - start=1 with mask!=0 and stop=0 is accepted. Latch mask, one_shot and D=max(dwell,1).
  - Next cycle is SCAN: sel=lowest set mask bit, en=1, line_strobe=1, busy=1. Latency is one cycle.
  - start with mask==0 is ignored. start and stop together is ignored (stop wins). Outputs hold en=0 and keep the last sel.
- SCAN:
  - en=1 for exactly D consecutive cycles per line. line_strobe is high only on the first of them.
  - After D cycles, advance to the next set mask bit in ascending order, wrapping 3->0.
  - A single-bit mask stays on the same line and reasserts line_strobe every D cycles.
- One-shot end: after the highest set mask line completes its D cycles, enter DONE for exactly one cycle with en=0, done=1, busy=0, sel held. Then go to IDLE.
- Continuous: wraps indefinitely. done is never asserted.
- stop in SCAN/BLANK: next cycle is IDLE with en=0, busy=0, no done pulse, sel held. stop takes precedence over a line advance in the same cycle.
- start while busy is ignored. Changes to mask, dwell or one_shot during a scan have no effect until the next accepted start.
- Invariant: en is never high outside SCAN. The sel change and en assertion happen on the same edge, so no glitching line appears.

Optional Feature:
- Macro SCAN_BLANK_EN.
- Defined: between consecutive lines, including the wrap and single-bit-mask repeats, insert one BLANK cycle. During BLANK, en=0, sel already equals the next line, and busy=1. line_strobe fires on the following SCAN cycle. There is no blank before the first line or before DONE.
- Undefined: lines are back-to-back with no en gap, and the BLANK state is not synthesised.

Test Plan:
1. rst=1 for 2 cycles during an active continuous scan -> sel=0, en=0, busy=0, done=0, line_strobe=0 after the first reset edge.
2. One-shot, mask=4'b1111, dwell=2 -> en=1 for 8 cycles with sel 0,0,1,1,2,2,3,3. line_strobe on cycles 1,3,5,7. Then one DONE cycle (en=0, done=1), then IDLE.
3. Continuous, mask=4'b1010, dwell=1 -> sel 1,3,1,3,… with en continuously 1. stop pulse -> en=0 and busy=0 next cycle, done stays 0.
4. dwell=0, mask=4'b0100, one-shot -> sel=2 with en=1 for 1 cycle, then done pulse. Separately, start with mask=0 -> busy stays 0 and en stays 0.
5. Reset asserted while sel=2, then start with mask=4'b1100, dwell=3 -> after reset outputs are zero. The new scan begins at sel=2, holds 3 cycles, then sel=3.
6. With SCAN_BLANK_EN, one-shot, mask=4'b1111, dwell=1 -> en 1,0,1,0,1,0,1 and sel 0,1,1,2,2,3,3, then a done pulse.

Source files
------------

// File: rtl/dec_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dec_scan_ctrl: walks enabled dec2to4 lines in ascending order, holding   |
// | each for a latched dwell time. Macro SCAN_BLANK_EN adds a blank cycle.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dec_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [3:0]         mask,
  output logic [1:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               line_strobe
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2, S_BLANK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_mask;
  logic [DWELL_W-1:0] r_dwell, r_cnt, w_cnt_nxt, w_dwell_in;
  logic               r_one_shot, w_accept;
  logic [1:0]         w_sel_nxt, w_lowest, w_next;
  logic               w_en_nxt, w_busy_nxt, w_done_nxt, w_strobe_nxt, w_last;

  function automatic logic [1:0] lowest_line(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (m[i]) r = 2'(i);
    return r;
  endfunction

  // Searching downward lets the nearest set line (smallest step) win; a
  // single-bit mask lands back on the current line after four steps.
  function automatic logic [1:0] next_line(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int k = 4; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign w_dwell_in = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign w_lowest   = lowest_line(mask);
  assign w_next     = next_line(r_mask, sel);
  assign w_last     = (r_mask >> sel) < 4'd2;

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = sel;
    w_en_nxt     = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    w_strobe_nxt = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (mask != 4'd0) && !stop) begin
          w_accept     = 1'b1;
          w_state_nxt  = S_SCAN;
          w_sel_nxt    = w_lowest;
          w_en_nxt     = 1'b1;
          w_busy_nxt   = 1'b1;
          w_strobe_nxt = 1'b1;
          w_cnt_nxt    = w_dwell_in - DWELL_W'(1);
        end
      end
      S_SCAN: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt != '0) begin
          w_cnt_nxt  = r_cnt - DWELL_W'(1);
          w_en_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
        end else if (r_one_shot && w_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_sel_nxt  = w_next;
          w_busy_nxt = 1'b1;
`ifdef SCAN_BLANK_EN
          w_state_nxt = S_BLANK;
`else
          w_en_nxt     = 1'b1;
          w_strobe_nxt = 1'b1;
          w_cnt_nxt    = r_dwell - DWELL_W'(1);
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt  = S_SCAN;
          w_en_nxt     = 1'b1;
          w_busy_nxt   = 1'b1;
          w_strobe_nxt = 1'b1;
          w_cnt_nxt    = r_dwell - DWELL_W'(1);
        end
      end
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mask      <= 4'd0;
      r_dwell     <= '0;
      r_one_shot  <= 1'b0;
      r_cnt       <= '0;
      sel         <= 2'd0;
      en          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      line_strobe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      sel         <= w_sel_nxt;
      en          <= w_en_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      line_strobe <= w_strobe_nxt;
      if (w_accept) begin
        r_mask     <= mask;
        r_dwell    <= w_dwell_in;
        r_one_shot <= one_shot;
      end
    end
  end

endmodule
`default_nettype wire
